// File: rtl/alu_request_arbiter.sv
// alu_request_arbiter: two requesters share one external combinational ALU.
// At most one request is granted per cycle; the ALU result is captured into a
// per-requester response slot on the granting edge (1-cycle latency) and held
// until the requester consumes it.
// Build option: define ALU_ARB_ROUND_ROBIN_EN for a 1-bit round-robin tie
// breaker; without it requester 0 always wins a tie (fixed priority).
module alu_request_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    // request side
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [N-1:0] req_a0,
    input  logic [N-1:0] req_b0,
    input  logic [N-1:0] req_a1,
    input  logic [N-1:0] req_b1,
    input  logic [3:0]   req_op0,
    input  logic [3:0]   req_op1,
    // response side
    output logic [1:0]   rsp_valid,
    input  logic [1:0]   rsp_ready,
    output logic [N-1:0] rsp_out0,
    output logic [N-1:0] rsp_out1,
    output logic [3:0]   rsp_flags0,
    output logic [3:0]   rsp_flags1,
    // shared ALU
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_control,
    input  logic [N-1:0] alu_out,
    input  logic         alu_negative,
    input  logic         alu_zero,
    input  logic         alu_carry,
    input  logic         alu_overflow
);

    // Per-requester views of the operand buses so slots can be generated.
    logic [N-1:0] op_a     [2];
    logic [N-1:0] op_b     [2];
    logic [3:0]   op_ctl   [2];
    logic [N-1:0] slot_out [2];
    logic [3:0]   slot_flg [2];

    logic [1:0]   slot_valid;
    logic [1:0]   slot_free;
    logic [1:0]   eligible;
    logic [1:0]   grant;
    logic         tie_to_one;
    logic [3:0]   alu_flags;

    assign op_a[0]   = req_a0;
    assign op_a[1]   = req_a1;
    assign op_b[0]   = req_b0;
    assign op_b[1]   = req_b1;
    assign op_ctl[0] = req_op0;
    assign op_ctl[1] = req_op1;

    // Flag packing order: {negative, zero, carry_out, overflow}.
    assign alu_flags = {alu_negative, alu_zero, alu_carry, alu_overflow};

    // A slot can take a new result if it is empty or is being drained now.
    assign slot_free = ~slot_valid | rsp_ready;
    assign eligible  = req_valid & slot_free;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    // Tie breaker: 0 favours requester 0, 1 favours requester 1.
    logic prio_q;
    logic prio_d;

    // Pointer moves only on a grant, to the requester that was not served.
    always_comb begin
        prio_d = prio_q;
        if (grant != 2'b00) begin
            prio_d = grant[0];
        end
    end

    // Pointer register; cold start favours requester 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

    assign tie_to_one = prio_q;
`else
    // Fixed priority: requester 0 always wins a tie.
    assign tie_to_one = 1'b0;
`endif

    // Grant selection: single eligible requester wins, ties go to the pointer.
    always_comb begin
        grant = 2'b00;
        if (!reset) begin
            case (eligible)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = tie_to_one ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;

    // Route the granted requester onto the ALU; idle cycles drive zeros.
    always_comb begin
        alu_a       = '0;
        alu_b       = '0;
        alu_control = 4'd0;
        if (grant[0]) begin
            alu_a       = op_a[0];
            alu_b       = op_b[0];
            alu_control = op_ctl[0];
        end else if (grant[1]) begin
            alu_a       = op_a[1];
            alu_b       = op_b[1];
            alu_control = op_ctl[1];
        end
    end

    // One response slot per requester.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            logic         valid_q;
            logic         valid_d;
            logic [N-1:0] out_q;
            logic [N-1:0] out_d;
            logic [3:0]   flags_q;
            logic [3:0]   flags_d;

            // A grant reloads the slot (even while it drains); a drain alone empties it.
            always_comb begin
                valid_d = valid_q;
                out_d   = out_q;
                flags_d = flags_q;
                if (grant[gi]) begin
                    valid_d = 1'b1;
                    out_d   = alu_out;
                    flags_d = alu_flags;
                end else if (valid_q && rsp_ready[gi]) begin
                    valid_d = 1'b0;
                end
            end

            // Slot registers; reset discards any held result.
            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_q <= 1'b0;
                    out_q   <= '0;
                    flags_q <= 4'd0;
                end else begin
                    valid_q <= valid_d;
                    out_q   <= out_d;
                    flags_q <= flags_d;
                end
            end

            assign slot_valid[gi] = valid_q;
            assign slot_out[gi]   = out_q;
            assign slot_flg[gi]   = flags_q;
        end
    endgenerate

    assign rsp_valid  = slot_valid;
    assign rsp_out0   = slot_out[0];
    assign rsp_out1   = slot_out[1];
    assign rsp_flags0 = slot_flg[0];
    assign rsp_flags1 = slot_flg[1];

endmodule

// File: doc/alu_request_arbiter.md
ALU_REQUEST_ARBITER -- requirements
Module: alu_request_arbiter

Interface
REQ-001 Parameter: N, default 4, operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  2  bit i: requester i presents an operation.
REQ-005 req_ready  output  2  bit i: operation from requester i is accepted this cycle.
REQ-006 req_a0, req_b0, req_a1, req_b1  input  N each  operands of requester 0 and requester 1.
REQ-007 req_op0, req_op1  input  4 each  ALU control code of requester 0 and requester 1.
REQ-008 rsp_valid  output  2  bit i: response slot i holds a result.
REQ-009 rsp_ready  input  2  bit i: requester i consumes its response this cycle.
REQ-010 rsp_out0, rsp_out1  output  N each  registered ALU result per requester.
REQ-011 rsp_flags0, rsp_flags1  output  4 each  registered {negative, zero, carry_out, overflow}.
REQ-012 alu_a, alu_b  output  N each; alu_control  output  4  drive the shared combinational ALU.
REQ-013 alu_out  input  N; alu_negative, alu_zero, alu_carry, alu_overflow  input  1 each  ALU results, valid in the same cycle.

Function
REQ-014 Slot i SHALL be free when rsp_valid[i]=0, or when rsp_valid[i]=1 and rsp_ready[i]=1 in the same cycle.
REQ-015 Requester i is eligible when req_valid[i]=1 and slot i is free.
REQ-016 At most one req_ready bit SHALL be high per cycle; req_ready is combinational from eligibility and the priority pointer.
REQ-017 One eligible requester: grant it; both eligible: grant the requester named by the priority pointer.
REQ-018 Granted cycle: alu_a/alu_b/alu_control SHALL equal the granted requester's operands and op; no grant: all three driven to 0.
REQ-019 On a grant, the edge SHALL capture alu_out and the four flags into slot i and set rsp_valid[i]=1; result latency is exactly 1 cycle.
REQ-020 rsp_valid[i] SHALL clear on rsp_valid[i]&&rsp_ready[i] unless a new grant to i occurs in the same cycle, in which case slot i reloads and stays valid (throughput 1 op/cycle).
REQ-021 rsp_out/rsp_flags SHALL hold stable while rsp_valid[i]=1 and rsp_ready[i]=0.
REQ-022 rsp_ready[i] while rsp_valid[i]=0 SHALL have no effect.
REQ-023 Priority pointer (1 bit) SHALL update only on a grant, to the requester not granted.
REQ-024 Requesters SHALL keep operands/op stable while req_valid=1 and req_ready=0; the block does not check this.
REQ-025 Slot i full and not draining: req_ready[i]=0; the other requester SHALL still be granted if eligible.

Reset
REQ-026 While reset=1 at an edge: rsp_valid=0, rsp_out0/1=0, rsp_flags0/1=0, priority pointer=requester 0.
REQ-027 While reset=1: req_ready=0 and alu_a/alu_b/alu_control=0.
REQ-028 Reset mid-operation SHALL discard held results without handshake; the first cycle after reset behaves as the cold-start cycle.

Configuration
REQ-029 Macro ALU_ARB_ROUND_ROBIN_EN defined: priority pointer behaves per REQ-023 (round-robin).
REQ-030 Macro ALU_ARB_ROUND_ROBIN_EN undefined: pointer removed; requester 0 always wins a tie (fixed priority); all other requirements unchanged.

Verification
REQ-031 Reset, then req_valid=01, a0=3, b0=2, op0=add code -> req_ready=01 same cycle; next cycle rsp_valid=01, rsp_out0=5, flags zero=0.
REQ-032 N=4, requester 1 add 7+1 -> rsp_out1=8 (4'b1000), negative=1, overflow=1, carry=0.
REQ-033 Both valid every cycle, rsp_ready=11 (round-robin build) -> grants alternate 01,10,01,10; each slot updates every other cycle.
REQ-034 Slot 0 full, rsp_ready[0]=0, both valid -> req_ready=10 only; rsp_out0 unchanged until rsp_ready[0]=1.
REQ-035 Slot 0 full, rsp_ready[0]=1 and req_valid[0]=1 same cycle, pointer at 0 -> req_ready=01, rsp_valid[0] stays 1 with new result.
REQ-036 Reset asserted one cycle after a grant with rsp_valid=11 -> next cycle rsp_valid=00, outputs 0; fixed-priority build: both valid -> req_ready=01 every cycle.
